// File: rtl/note_seq_pkg.sv
// Shared types and widths for the note sequencer and its helpers.
package note_seq_pkg;

    localparam int NOTE_W = 32;
    localparam int DUR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } score_entry_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// clr restarts the count so the next tick lands exactly TICK_DIV cycles later.
module tick_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == CW'(TICK_DIV - 1));

    // Count up to TICK_DIV-1, then wrap; clear and reset restart from zero.
    always_ff @(posedge clk) begin
        if (!resetn || clr || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays a stored score of (half-period, duration) entries to a tone generator,
// with an optional silent gap after each entry and optional looping.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TICK_DIV  = 12_500_000,
    parameter int GAP_TICKS = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NOTE_W-1:0]          wr_note,
    input  logic [DUR_W-1:0]           wr_dur,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    output logic [NOTE_W-1:0]          note,
    output logic                       sound,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   index
);

    localparam int AW    = $clog2(DEPTH);
    localparam int GW    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int CNT_W = (GW > DUR_W) ? GW : DUR_W;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    score_entry_t mem [DEPTH];
    score_entry_t rd_reg;

    seq_state_t        state_reg;
    logic [AW-1:0]     index_reg;
    logic [NOTE_W-1:0] note_reg;
    logic              sound_reg;
    logic              done_reg;
    logic [DUR_W-1:0]  dur_reg;
    logic [CNT_W-1:0]  tick_cnt_reg;

    logic          tick;
    logic          clr;
    logic          play_end;
    logic          gap_end;
    logic          advance;
    logic          more;
    logic [AW:0]   index_inc;
    logic [AW-1:0] adv_idx;
    logic [AW-1:0] rd_addr;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .resetn(resetn),
        .clr   (clr),
        .tick  (tick)
    );

    // Advance decision and the read address of the entry that LOAD will see.
    // The read is issued on the edge that enters LOAD, so LOAD has the data.
    always_comb begin
        index_inc = {1'b0, index_reg} + (AW+1)'(1);
        more      = (index_inc < len);
        adv_idx   = more ? index_inc[AW-1:0] : '0;
        play_end  = (state_reg == PLAY) && tick &&
                    (tick_cnt_reg == (CNT_W'(dur_reg) - CNT_W'(1)));
        gap_end   = (state_reg == GAP) && tick && (tick_cnt_reg == GAP_LAST);
        advance   = ((state_reg == LOAD) && (rd_reg.dur == '0)) ||
                    (play_end && (GAP_TICKS == 0)) ||
                    gap_end;
        clr       = !((state_reg == PLAY) || (state_reg == GAP)) || play_end || gap_end;
        rd_addr   = (state_reg == IDLE) ? '0 : adv_idx;
    end

    // Score memory: one write port, one registered read, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_note, wr_dur};
        end
        rd_reg <= mem[rd_addr];
    end

    // Sequencer FSM; stop outranks everything, advance outranks per-state work.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            note_reg     <= '0;
            sound_reg    <= 1'b0;
            done_reg     <= 1'b0;
            dur_reg      <= '0;
            tick_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (stop) begin
                state_reg <= IDLE;
                note_reg  <= '0;
                sound_reg <= 1'b0;
            end else if (advance) begin
                sound_reg    <= 1'b0;
                tick_cnt_reg <= '0;
                if (more || loop) begin
                    state_reg <= LOAD;
                    index_reg <= adv_idx;
                end else begin
                    state_reg <= IDLE;
                    note_reg  <= '0;
                    done_reg  <= 1'b1;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            if (len == '0) begin
                                done_reg <= 1'b1;
                            end else begin
                                state_reg <= LOAD;
                                index_reg <= '0;
                            end
                        end
                    end
                    LOAD: begin
                        state_reg    <= PLAY;
                        note_reg     <= rd_reg.note;
                        dur_reg      <= rd_reg.dur;
                        sound_reg    <= (rd_reg.note != '0);
                        tick_cnt_reg <= '0;
                    end
                    PLAY: begin
                        if (play_end) begin
                            state_reg    <= GAP;
                            sound_reg    <= 1'b0;
                            tick_cnt_reg <= '0;
                        end else if (tick) begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign note  = note_reg;
    assign sound = sound_reg;
    assign done  = done_reg;
    assign index = index_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1, DEPTH=16.
// Inputs change on the falling edge; t counts rising edges after the one
// that samples start, and outputs are observed on the falling edge after edge t.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_note = '0;
    logic [7:0]  wr_dur = '0;
    logic [4:0]  len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [31:0] note;
    logic        sound;
    logic        busy;
    logic        done;
    logic [3:0]  index;

    int total = 0;
    int bad = 0;

    note_sequencer #(
        .DEPTH    (16),
        .TICK_DIV (4),
        .GAP_TICKS(1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_note(wr_note),
        .wr_dur (wr_dur),
        .len    (len),
        .start  (start),
        .stop   (stop),
        .loop   (loop),
        .note   (note),
        .sound  (sound),
        .busy   (busy),
        .done   (done),
        .index  (index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [31:0] n, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_note = n;
        wr_dur  = d;
        @(negedge clk);
        wr_en = 1'b0;
        $display("write addr=%0d note=%0d dur=%0d", a, n, d);
    endtask

    // Leaves the bench at the falling edge after edge t=1.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_and_settle();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic        exp_sound;
    logic [31:0] exp_note;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst sound", 32'(sound), 32'd0);
        check("rst note", note, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst index", 32'(index), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        write_entry(4'd0, 32'd100, 8'd2);
        write_entry(4'd1, 32'd0, 8'd1);
        write_entry(4'd2, 32'd200, 8'd3);
        len = 5'd3;

        // start and stop together in IDLE: stop wins
        $display("txn: start+stop in idle");
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("conflict busy", 32'(busy), 32'd0);
        check("conflict done", 32'(done), 32'd0);
        @(negedge clk);
        check("conflict busy2", 32'(busy), 32'd0);

        // len=0: immediate done pulse, never sounds
        $display("txn: start with len=0");
        len = 5'd0;
        pulse_start();
        check("len0 done t1", 32'(done), 32'd1);
        check("len0 busy t1", 32'(busy), 32'd0);
        check("len0 sound t1", 32'(sound), 32'd0);
        @(negedge clk);
        check("len0 done t2", 32'(done), 32'd0);
        check("len0 sound t2", 32'(sound), 32'd0);
        len = 5'd3;
        @(negedge clk);

        // Three-entry score
        $display("txn: three-entry score");
        pulse_start();
        for (int t = 1; t <= 44; t++) begin
            exp_sound = ((t >= 2) && (t <= 9)) || ((t >= 24) && (t <= 35));
            if ((t >= 2) && (t <= 14))       exp_note = 32'd100;
            else if ((t >= 24) && (t <= 39)) exp_note = 32'd200;
            else                             exp_note = 32'd0;
            check($sformatf("s1 sound t=%0d", t), 32'(sound), 32'(exp_sound));
            check($sformatf("s1 note t=%0d", t), note, exp_note);
            check($sformatf("s1 done t=%0d", t), 32'(done), (t == 40) ? 32'd1 : 32'd0);
            check($sformatf("s1 busy t=%0d", t), 32'(busy), (t <= 39) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Reset mid-PLAY, then replay from entry 0
        $display("txn: reset mid-play");
        pulse_start();
        repeat (3) @(negedge clk);
        check("pre-rst sound t4", 32'(sound), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("mid-rst sound", 32'(sound), 32'd0);
        check("mid-rst note", note, 32'd0);
        check("mid-rst busy", 32'(busy), 32'd0);
        check("mid-rst done", 32'(done), 32'd0);
        check("mid-rst index", 32'(index), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        pulse_start();
        @(negedge clk);
        check("replay sound t2", 32'(sound), 32'd1);
        check("replay note t2", note, 32'd100);
        check("replay index t2", 32'(index), 32'd0);
        stop_and_settle();

        // Zero-duration entry is skipped
        $display("txn: skip entry");
        write_entry(4'd0, 32'd50, 8'd0);
        write_entry(4'd1, 32'd60, 8'd1);
        len = 5'd2;
        pulse_start();
        for (int t = 1; t <= 12; t++) begin
            exp_sound = (t >= 3) && (t <= 6);
            check($sformatf("s2 sound t=%0d", t), 32'(sound), 32'(exp_sound));
            if (t == 3) check("s2 note t=3", note, 32'd60);
            check($sformatf("s2 done t=%0d", t), 32'(done), (t == 11) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Looping single entry, then stop
        $display("txn: loop then stop");
        write_entry(4'd0, 32'd70, 8'd1);
        len  = 5'd1;
        loop = 1'b1;
        pulse_start();
        for (int t = 1; t <= 23; t++) begin
            exp_sound = ((t >= 2) && (t <= 5)) || ((t >= 11) && (t <= 14)) ||
                        ((t >= 20) && (t <= 23));
            check($sformatf("s3 sound t=%0d", t), 32'(sound), 32'(exp_sound));
            if (exp_sound) check($sformatf("s3 note t=%0d", t), note, 32'd70);
            if (t == 23) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        check("s3 stop sound", 32'(sound), 32'd0);
        check("s3 stop note", note, 32'd0);
        check("s3 stop busy", 32'(busy), 32'd0);
        for (int t = 0; t < 5; t++) begin
            check($sformatf("s3 no done %0d", t), 32'(done), 32'd0);
            @(negedge clk);
        end

        // Rewrite entry 0 while it plays
        $display("txn: write during play");
        pulse_start();
        for (int t = 1; t <= 12; t++) begin
            if (t == 3) begin
                wr_en   = 1'b1;
                wr_addr = 4'd0;
                wr_note = 32'd90;
                wr_dur  = 8'd1;
            end
            if (t == 4) begin
                wr_en = 1'b0;
                $display("write addr=0 note=90 dur=1 (during play)");
            end
            if ((t >= 4) && (t <= 5)) check($sformatf("s5 note t=%0d", t), note, 32'd70);
            if (t == 11) begin
                check("s5 note t=11", note, 32'd90);
                check("s5 sound t=11", 32'(sound), 32'd1);
            end
            @(negedge clk);
        end
        loop = 1'b0;
        stop_and_settle();
        check("end busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of score entries (power of 2).
REQ-002 SHALL have parameter TICK_DIV, default 12_500_000, meaning clk cycles per duration tick (>=2).
REQ-003 SHALL have parameter GAP_TICKS, default 1, meaning the silent ticks inserted after each entry (0 = no gap).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port wr_en, input, 1 bit: score write strobe.
REQ-007 SHALL have port wr_addr, input, log2(DEPTH) bits: score write address.
REQ-008 SHALL have port wr_note, input, 32 bits: half-period count for the tone generator (0 = rest).
REQ-009 SHALL have port wr_dur, input, 8 bits: entry duration in ticks (0 = skip entry).
REQ-010 SHALL have port len, input, log2(DEPTH)+1 bits: number of entries to play (0..DEPTH).
REQ-011 SHALL have ports start and stop, inputs, 1 bit each: control pulses.
REQ-012 SHALL have port loop, input, 1 bit: restart at entry 0 after the last entry.
REQ-013 SHALL have port note, output, 32 bits: half-period to the tone generator.
REQ-014 SHALL have port sound, output, 1 bit: tone enable.
REQ-015 SHALL have ports busy, done and index: outputs of 1, 1 and log2(DEPTH) bits; index is the current entry.

Function
REQ-016 SHALL store each score write when wr_en=1 at a clk edge, in any state; an entry already loaded is unaffected until it is next loaded.
REQ-017 SHALL implement states IDLE, LOAD, PLAY and GAP, all with registered outputs.
REQ-018 IDLE: on start=1 and stop=0, SHALL go to LOAD with index=0; if len=0, SHALL stay in IDLE and pulse done on the next cycle.
REQ-019 LOAD (1 cycle): SHALL latch note and duration of entry index; if dur=0, SHALL advance per REQ-022 without PLAY or GAP.
REQ-020 PLAY: SHALL last exactly dur*TICK_DIV cycles; note = latched value; sound = 1 if note != 0, else 0.
REQ-021 GAP: SHALL last exactly GAP_TICKS*TICK_DIV cycles with sound=0 and note held; when GAP_TICKS=0, SHALL skip GAP.
REQ-022 Advance rule:
- if index < len-1: SHALL increment index and go to LOAD;
- else if loop=1: SHALL set index=0 and go to LOAD;
- else: SHALL go to IDLE with done=1 for exactly one cycle.
REQ-023 The tick prescaler SHALL clear on entry to PLAY and GAP; the tick counter SHALL never wrap mid-entry.
REQ-024 Start latency: with start sampled at edge k, state SHALL be LOAD after k+1 and sound/note valid after k+2.
REQ-025 stop=1 SHALL override start, in any state: go to IDLE on the next edge, sound=0, note=0, no done pulse.
REQ-026 start while busy SHALL be ignored.
REQ-027 busy SHALL be 1 in all states except IDLE.
REQ-028 In IDLE, note SHALL be 0 and sound 0.
REQ-029 len SHALL be sampled on each advance; a len change mid-play SHALL take effect at the next advance.

Reset
REQ-030 resetn=0 at a clk edge SHALL force IDLE, index=0, note=0, sound=0, busy=0, done=0 and clear the prescaler, including mid-PLAY.
REQ-031 Reset SHALL NOT clear score memory (contents undefined after power-up).

Structure
REQ-032 State encodings and the NOTE_W=32 and DUR_W=8 widths SHALL live in shared package note_seq_pkg.
REQ-033 The prescaler SHALL be a sub-module tick_prescaler with inputs clk, resetn and clr, output tick, and parameter TICK_DIV.
REQ-034 Score memory SHALL be inferable as distributed or block RAM: one write port and one registered read.

Verification (TICK_DIV=4, GAP_TICKS=1, DEPTH=16)
REQ-035 Scenario, three entries:
- stimulus: score {100,2},{0,1},{200,3}; len=3; start at edge k.
- required: sound=1 with note=100 for edges k+2..k+9; sound=0 for k+10..k+23; sound=1 with note=200 for k+24..k+35; done=1 for one cycle after edge k+40; busy=0 thereafter.
REQ-036 Scenario, skip entry: score {50,0},{60,1}, len=2, start -> the first PLAY has note=60 and starts at edge k+3.
REQ-037 Scenario, loop: loop=1, len=1, entry {70,1} -> a 4-cycle sound, then a 4-cycle gap, repeated 3 times; stop -> sound=0 on the next edge, no done.
REQ-038 Scenario, reset mid-PLAY: resetn=0 mid-PLAY -> all outputs zero on the next edge; a following start replays from entry 0 with the score intact.
REQ-039 Scenario, conflicts: start=stop=1 in IDLE -> stays IDLE; len=0 with start -> done pulse, sound never 1.
REQ-040 Scenario, write during play: rewrite entry 0 while entry 0 plays -> the current note is unchanged; the new value is heard on the next loop pass.
